blit_coordgen: RTL and testbench
================================

# blit_coordgen

Command sequencer at the front of the blitter pipeline. It accepts one blit command at a time from the register interface and walks the destination rectangle row by row, one pixel per cycle. For each pixel it presents destination and source coordinates, a font bit index and the latched command to `blit_addrgen` (stage p1). It honours the downstream `p2_ready` stall and reports busy/done back to the register interface.

## Interface
Parameters:
- none; widths fixed by the pipeline (16-bit coordinates, 5-bit command codes from `blit.vh`)

Ports:
- `clock`  in  1  pipeline clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle command strobe from the register interface
- `reg_command`  in  5  `BLIT_RECT`, `BLIT_COPY` or `BLIT_TEXT`; sampled on accepted `start`
- `reg_x`, `reg_y`  in  16 each  destination top-left
- `reg_src_x`, `reg_src_y`  in  16 each  source top-left; ignored for RECT
- `reg_width`, `reg_height`  in  16 each  rectangle size in pixels
- `p2_ready`  in  1  downstream accepts the current p1 pixel
- `p1_valid`  out  1  pixel present
- `p1_x`, `p1_y`  out  16 each  destination coordinate
- `p1_src_x`, `p1_src_y`  out  16 each  source coordinate
- `p1_bit_index`  out  3  font bit within the source byte (TEXT only, else 0)
- `p1_command`  out  5  command latched at start
- `busy`  out  1  command in progress
- `done`  out  1  one-cycle pulse after the last pixel is accepted

## Operation
- States: IDLE and RUN.
- IDLE + `start`:
  - Latch all `reg_*` inputs.
  - If width==0 or height==0: stay IDLE, pulse `done` next cycle, emit no pixels.
  - Otherwise go to RUN with the pixel at (reg_x, reg_y) on the outputs.
- `start` while in RUN is ignored. There is no queue.
- Transfer occurs on a rising edge with `p1_valid && p2_ready`. Without a transfer, every p1 output holds its value.
- Advance on transfer (column counter c, row counter r):
  - `p1_x` increments by 1.
  - COPY: `p1_src_x` increments by 1.
  - TEXT: `p1_bit_index` increments mod 8; `p1_src_x` increments when the bit index wraps 7→0.
  - RECT: src outputs stay 0.
- End of row (c == width-1):
  - `p1_x` ← x0, `p1_src_x` ← src_x0, `p1_bit_index` ← 0.
  - `p1_y` and `p1_src_y` each increment by 1.
- Last pixel (c == width-1, r == height-1) transferred: next state IDLE, `p1_valid` 0, `done` 1 for one cycle.
- Arithmetic is 16-bit unsigned and wraps mod 2^16. No clipping here; `blit_addrgen` clips.
- Unknown command code: treated as a zero-size command (done pulse, no pixels).
- `busy` = (state == RUN).

## Timing
- Reset values: `p1_valid`=0, `busy`=0, `done`=0. All coordinates, `p1_bit_index` and `p1_command` are 0. State is IDLE.
- `start` at edge N → `p1_valid`=1 and `busy`=1 from N+1.
- Throughput is 1 pixel per cycle while `p2_ready`=1. Total cycles from start to done = width×height + stall cycles + 1.
- `done` is asserted in the same cycle `busy` falls.
- `reset_n` low mid-command: abort immediately to reset values. No done pulse.
- All outputs are registered. There is no combinational path from `p2_ready` to any output.

## Configuration
- `BLIT_TEXT_EN` defined: TEXT is supported as above (bit-expanded source, 8 pixels per source byte).
- `BLIT_TEXT_EN` undefined: `BLIT_TEXT` is an unknown command (immediate done, no pixels). `p1_bit_index` is tied to 0 and the bit counter logic is removed.

## Test plan
- RECT, x=10 y=20 w=3 h=2, `p2_ready`=1 → six pixels (10,20),(11,20),(12,20),(10,21),(11,21),(12,21) on consecutive cycles; done 7 cycles after start.
- COPY, dst (0,0), src (100,50), w=2 h=2; `p2_ready` low for 3 cycles after the 2nd pixel → outputs hold (1,0)/(101,50) through the stall; sequence resumes with no loss or duplication.
- TEXT, w=10 h=1, src_x=40 → bit_index 0..7,0,1; src_x 40×8 then 41×2; second row (h=2) restarts at bit 0, src_x 40, src_y+1.
- width=0 → no `p1_valid`, done pulse 1 cycle after start; `start` during RUN ignored (pixel count unchanged).
- Reset asserted at pixel 5 of a 4×4 RECT → outputs return to 0 asynchronously, no done; a new start afterwards runs cleanly.
- x=0xFFFE w=4 → `p1_x` sequence FFFE, FFFF, 0000, 0001.

Source files
------------

// File: rtl/blit_coordgen.sv
// Blitter front-end sequencer: walks the destination rectangle one pixel per cycle.
// Define BLIT_TEXT_EN to support bit-expanded TEXT commands; otherwise TEXT is rejected.
module blit_coordgen (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [4:0]  reg_command,
    input  logic [15:0] reg_x,
    input  logic [15:0] reg_y,
    input  logic [15:0] reg_src_x,
    input  logic [15:0] reg_src_y,
    input  logic [15:0] reg_width,
    input  logic [15:0] reg_height,
    input  logic        p2_ready,
    output logic        p1_valid,
    output logic [15:0] p1_x,
    output logic [15:0] p1_y,
    output logic [15:0] p1_src_x,
    output logic [15:0] p1_src_y,
    output logic [2:0]  p1_bit_index,
    output logic [4:0]  p1_command,
    output logic        busy,
    output logic        done,
    output logic        debug_state
);

    localparam logic [4:0] BLIT_RECT = 5'h01;
    localparam logic [4:0] BLIT_COPY = 5'h02;
    localparam logic [4:0] BLIT_TEXT = 5'h03;
`ifdef BLIT_TEXT_EN
    localparam logic TEXT_EN = 1'b1;
`else
    localparam logic TEXT_EN = 1'b0;
`endif

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t      state, state_next;
    logic        done_next;
    logic [15:0] x0, src_x0, width_r, height_r, col, row;
    logic        xfer, row_end, last, cmd_known, launch, src_step, text_wrap;

    // Handshake: a pixel moves on a rising edge when p1_valid && p2_ready; with no
    // transfer every p1 output holds. p1_valid never depends on p2_ready combinationally.
    assign xfer      = p1_valid && p2_ready;
    assign row_end   = (col == (width_r - 16'd1));
    assign last      = row_end && (row == (height_r - 16'd1));
    assign cmd_known = (reg_command == BLIT_RECT) || (reg_command == BLIT_COPY) ||
                       (TEXT_EN && (reg_command == BLIT_TEXT));
    assign launch    = cmd_known && (reg_width != 16'd0) && (reg_height != 16'd0);
    assign src_step  = (p1_command == BLIT_COPY) || text_wrap;

    assign p1_valid    = (state == S_RUN);
    assign busy        = (state == S_RUN);
    assign debug_state = state;

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (launch) state_next = S_RUN;
                    else        done_next  = 1'b1;
                end
            end
            S_RUN: begin
                if (xfer && last) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

`ifdef BLIT_TEXT_EN
    // Bit counter steps only for TEXT; the source byte advances when it wraps 7 -> 0.
    assign text_wrap = (p1_command == BLIT_TEXT) && (p1_bit_index == 3'd7);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p1_bit_index <= 3'd0;
        end else if (state == S_IDLE) begin
            if (start && launch) p1_bit_index <= 3'd0;
        end else if (xfer) begin
            if (row_end)                        p1_bit_index <= 3'd0;
            else if (p1_command == BLIT_TEXT)   p1_bit_index <= p1_bit_index + 3'd1;
        end
    end
`else
    assign text_wrap    = 1'b0;
    assign p1_bit_index = 3'd0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p1_command <= 5'd0;
            p1_x       <= 16'd0;
            p1_y       <= 16'd0;
            p1_src_x   <= 16'd0;
            p1_src_y   <= 16'd0;
            x0         <= 16'd0;
            src_x0     <= 16'd0;
            width_r    <= 16'd0;
            height_r   <= 16'd0;
            col        <= 16'd0;
            row        <= 16'd0;
        end else if (state == S_IDLE) begin
            if (start) begin
                p1_command <= reg_command;
                if (launch) begin
                    p1_x     <= reg_x;
                    p1_y     <= reg_y;
                    x0       <= reg_x;
                    width_r  <= reg_width;
                    height_r <= reg_height;
                    col      <= 16'd0;
                    row      <= 16'd0;
                    // RECT has no source; keep its source outputs at zero.
                    if (reg_command == BLIT_RECT) begin
                        p1_src_x <= 16'd0;
                        p1_src_y <= 16'd0;
                        src_x0   <= 16'd0;
                    end else begin
                        p1_src_x <= reg_src_x;
                        p1_src_y <= reg_src_y;
                        src_x0   <= reg_src_x;
                    end
                end
            end
        end else if (xfer) begin
            if (row_end) begin
                col      <= 16'd0;
                row      <= row + 16'd1;
                p1_x     <= x0;
                p1_src_x <= src_x0;
                p1_y     <= p1_y + 16'd1;
                if (p1_command != BLIT_RECT) p1_src_y <= p1_src_y + 16'd1;
            end else begin
                col  <= col + 16'd1;
                p1_x <= p1_x + 16'd1;
                if (src_step) p1_src_x <= p1_src_x + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_blit_coordgen.sv
// Self-checking bench for blit_coordgen: directed scenarios plus randomized commands
// checked against a rectangle-walk reference model.
module tb_blit_coordgen;

    localparam int W = 72;
    localparam logic [4:0] BLIT_RECT = 5'h01;
    localparam logic [4:0] BLIT_COPY = 5'h02;
    localparam logic [4:0] BLIT_TEXT = 5'h03;
`ifdef BLIT_TEXT_EN
    localparam bit TEXT_EN = 1'b1;
`else
    localparam bit TEXT_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  reg_command = 5'd0;
    logic [15:0] reg_x = 16'd0, reg_y = 16'd0, reg_src_x = 16'd0, reg_src_y = 16'd0;
    logic [15:0] reg_width = 16'd0, reg_height = 16'd0;
    logic        p2_ready = 1'b1;
    logic        p1_valid, busy, done, debug_state;
    logic [15:0] p1_x, p1_y, p1_src_x, p1_src_y;
    logic [2:0]  p1_bit_index;
    logic [4:0]  p1_command;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    blit_coordgen dut (
        .clock(clock), .reset_n(reset_n), .start(start), .reg_command(reg_command),
        .reg_x(reg_x), .reg_y(reg_y), .reg_src_x(reg_src_x), .reg_src_y(reg_src_y),
        .reg_width(reg_width), .reg_height(reg_height), .p2_ready(p2_ready),
        .p1_valid(p1_valid), .p1_x(p1_x), .p1_y(p1_y), .p1_src_x(p1_src_x),
        .p1_src_y(p1_src_y), .p1_bit_index(p1_bit_index), .p1_command(p1_command),
        .busy(busy), .done(done), .debug_state(debug_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    function automatic logic [W-1:0] pack(input logic [4:0] cmd, input logic [15:0] x,
        input logic [15:0] y, input logic [15:0] sx, input logic [15:0] sy, input logic [2:0] b);
        return {cmd, x, y, sx, sy, b};
    endfunction

    function automatic logic [W-1:0] observed();
        return pack(p1_command, p1_x, p1_y, p1_src_x, p1_src_y, p1_bit_index);
    endfunction

    function automatic bit cmd_known(input logic [4:0] c);
        return (c == BLIT_RECT) || (c == BLIT_COPY) || (TEXT_EN && (c == BLIT_TEXT));
    endfunction

    // Reference model: the full pixel list of a command, row-major.
    task automatic build_model(input logic [4:0] cmd, input logic [15:0] x, input logic [15:0] y,
        input logic [15:0] sx, input logic [15:0] sy, input logic [15:0] w, input logic [15:0] h);
        logic [15:0] px, py, psx, psy;
        logic [2:0]  pb;
        exp_q.delete();
        if (!cmd_known(cmd) || w == 16'd0 || h == 16'd0) return;
        for (int r = 0; r < int'(h); r++) begin
            for (int c = 0; c < int'(w); c++) begin
                px = x + 16'(c);
                py = y + 16'(r);
                psx = 16'd0; psy = 16'd0; pb = 3'd0;
                if (cmd == BLIT_COPY) begin
                    psx = sx + 16'(c); psy = sy + 16'(r);
                end else if (cmd == BLIT_TEXT) begin
                    psx = sx + 16'(c / 8); psy = sy + 16'(r); pb = 3'(c % 8);
                end
                exp_q.push_back(pack(cmd, px, py, psx, psy, pb));
            end
        end
    endtask

    task automatic drive_regs(input logic [4:0] cmd, input logic [15:0] x, input logic [15:0] y,
        input logic [15:0] sx, input logic [15:0] sy, input logic [15:0] w, input logic [15:0] h);
        reg_command = cmd; reg_x = x; reg_y = y; reg_src_x = sx; reg_src_y = sy;
        reg_width = w; reg_height = h;
    endtask

    // ready_mode: 0 always ready, 1 random, 2 three stall cycles on the 2nd pixel
    task automatic run_cmd(input string name, input logic [4:0] cmd, input logic [15:0] x,
        input logic [15:0] y, input logic [15:0] sx, input logic [15:0] sy, input logic [15:0] w,
        input logic [15:0] h, input int ready_mode, input bit inject_start);
        int cyc, stalls, xfers, stall_left, budget, n_exp;
        bit seen_done;
        logic rdy;
        build_model(cmd, x, y, sx, sy, w, h);
        n_exp = exp_q.size();
        budget = n_exp * 5 + 20;
        cyc = 0; stalls = 0; xfers = 0; stall_left = 3; seen_done = 1'b0;
        @(negedge clock);
        drive_regs(cmd, x, y, sx, sy, w, h);
        start = 1'b1;
        while (!seen_done && cyc < budget) begin
            @(negedge clock);
            start = 1'b0;
            cyc++;
            if (inject_start && cyc == 3) begin
                start = 1'b1;
                reg_width = 16'd7; reg_x = 16'h5555;
            end
            if (done) begin
                seen_done = 1'b1;
                checks++;
                if (cyc != n_exp + stalls + 1)
                    $display("FAIL %s done_latency: got %0d cycles, expected %0d", name, cyc, n_exp + stalls + 1);
                if (cyc != n_exp + stalls + 1) errors++;
                checks++;
                if (exp_q.size() != 0 || busy !== 1'b0 || p1_valid !== 1'b0) begin
                    $display("FAIL %s done_state: missing=%0d busy=%b valid=%b, expected 0/0/0",
                             name, exp_q.size(), busy, p1_valid);
                    errors++;
                end
            end else if (p1_valid) begin
                case (ready_mode)
                    0: rdy = 1'b1;
                    1: rdy = ($urandom_range(0, 3) != 0);
                    default: begin
                        rdy = !(xfers == 1 && stall_left > 0);
                        if (!rdy) stall_left--;
                    end
                endcase
                p2_ready = rdy;
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL %s extra_pixel: got %h, expected none", name, observed());
                    errors++;
                end else if (observed() !== exp_q[0]) begin
                    $display("FAIL %s pixel%0d: got %h, expected %h", name, xfers, observed(), exp_q[0]);
                    errors++;
                end
                if (rdy) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    xfers++;
                end else begin
                    stalls++;
                end
            end else begin
                checks++;
                errors++;
                $display("FAIL %s idle_gap: valid=%b done=%b at cycle %0d, expected valid or done",
                         name, p1_valid, done, cyc);
            end
        end
        start = 1'b0;
        p2_ready = 1'b1;
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles", name, budget);
        end else begin
            @(negedge clock);
            if (done !== 1'b0 || p1_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s done_pulse: done=%b valid=%b after pulse, expected 0/0", name, done, p1_valid);
            end
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({p1_valid, busy, done, debug_state} !== 4'b0 || observed() !== '0) begin
            errors++;
            $display("FAIL %s: valid=%b busy=%b done=%b state=%b outs=%h, expected all 0",
                     name, p1_valid, busy, done, debug_state, observed());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check_zero("reset_values");
        reset_n = 1'b1;
        @(negedge clock);
        check_zero("post_reset_idle");
    endtask

    task automatic test_rect();
        run_cmd("rect", BLIT_RECT, 16'd10, 16'd20, 16'd77, 16'd88, 16'd3, 16'd2, 0, 1'b0);
    endtask

    task automatic test_copy_stall();
        run_cmd("copy_stall", BLIT_COPY, 16'd0, 16'd0, 16'd100, 16'd50, 16'd2, 16'd2, 2, 1'b0);
    endtask

    task automatic test_text();
        run_cmd("text", BLIT_TEXT, 16'd5, 16'd6, 16'd40, 16'd9, 16'd10, 16'd2, 0, 1'b0);
    endtask

    task automatic test_zero_and_ignore();
        run_cmd("width0", BLIT_RECT, 16'd1, 16'd2, 16'd0, 16'd0, 16'd0, 16'd4, 0, 1'b0);
        run_cmd("height0", BLIT_COPY, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0, 0, 1'b0);
        run_cmd("unknown_cmd", 5'h1F, 16'd1, 16'd2, 16'd3, 16'd4, 16'd3, 16'd3, 0, 1'b0);
        run_cmd("start_in_run", BLIT_COPY, 16'd8, 16'd9, 16'd30, 16'd31, 16'd4, 16'd2, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int popped;
        build_model(BLIT_RECT, 16'd3, 16'd4, 16'd0, 16'd0, 16'd4, 16'd4);
        popped = 0;
        p2_ready = 1'b1;
        @(negedge clock);
        drive_regs(BLIT_RECT, 16'd3, 16'd4, 16'd0, 16'd0, 16'd4, 16'd4);
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (popped == 4) break;
            if (p1_valid) begin
                void'(exp_q.pop_front());
                popped++;
            end
        end
        checks++;
        if (p1_valid !== 1'b1 || exp_q.size() == 0 || observed() !== exp_q[0]) begin
            errors++;
            $display("FAIL reset_mid_pixel5: valid=%b got %h, expected valid pixel (3,5)", p1_valid, observed());
        end
        reset_n = 1'b0;
        #1;
        check_zero("reset_mid_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (done !== 1'b0 || p1_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_no_done: done=%b valid=%b, expected 0/0", done, p1_valid);
            end
        end
        reset_n = 1'b1;
        run_cmd("after_reset", BLIT_RECT, 16'd1, 16'd1, 16'd0, 16'd0, 16'd2, 16'd2, 0, 1'b0);
    endtask

    task automatic test_wrap();
        run_cmd("wrap_x", BLIT_RECT, 16'hFFFE, 16'hFFFF, 16'd0, 16'd0, 16'd4, 16'd2, 0, 1'b0);
        run_cmd("wrap_src", BLIT_COPY, 16'd2, 16'd3, 16'hFFFF, 16'hFFFF, 16'd3, 16'd2, 1, 1'b0);
    endtask

    task automatic test_random();
        logic [4:0] cmd;
        for (int n = 0; n < 16; n++) begin
            case ($urandom_range(0, 4))
                0: cmd = BLIT_RECT;
                1: cmd = BLIT_COPY;
                2, 3: cmd = BLIT_TEXT;
                default: cmd = 5'($urandom_range(4, 31));
            endcase
            run_cmd("random", cmd, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    16'($urandom_range(0, 19)), 16'($urandom_range(0, 3)), 1, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_rect();
        test_copy_stall();
        test_text();
        test_zero_and_ignore();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
